hs_link_buffer: RTL and testbench
=================================

HS_LINK_BUFFER -- requirements
Module: hs_link_buffer

Interface
REQ-001 Parameter DATA_W, default 16, payload width in bits.
REQ-002 Parameter DEPTH, default 4, number of buffer entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_req  input  1  producer four-phase request; in_data valid while high.
REQ-006 in_ack  output  1  producer four-phase acknowledge.
REQ-007 in_data  input  DATA_W  producer payload (bundled data, held stable from in_req rise until in_ack rise).
REQ-008 out_req  output  1  consumer four-phase request.
REQ-009 out_ack  input  1  consumer four-phase acknowledge.
REQ-010 out_data  output  DATA_W  consumer payload, registered, stable while out_req high.
REQ-011 count  output  clog2(DEPTH)+1  number of occupied entries.
REQ-012 full  output  1  high when count == DEPTH.
REQ-013 empty  output  1  high when count == 0.

Function
REQ-014 The block SHALL contain one clock and one synchronous active-high reset; it links two four-phase handshake domains through a DEPTH-entry circular buffer.
REQ-015 Sampled request req_s and sampled acknowledge ack_s SHALL equal in_req and out_ack directly, or their synchronised versions per REQ-031.
REQ-016 Input FSM states: IN_IDLE, IN_ACK.
REQ-017 IN_IDLE: if req_s == 1 and full == 0, write in_data to buf[wr_ptr]; wr_ptr += 1 mod DEPTH; in_ack <= 1; next state IN_ACK.
REQ-018 IN_IDLE with req_s == 1 and full == 1: in_ack stays 0 and no write occurs; the write occurs on the first edge on which full == 0.
REQ-019 IN_ACK: when req_s == 0, in_ack <= 0 and next state is IN_IDLE; otherwise hold.
REQ-020 Output FSM states: OUT_IDLE, OUT_REQ, OUT_WAIT.
REQ-021 OUT_IDLE: if empty == 0 and ack_s == 0, out_data <= buf[rd_ptr]; out_req <= 1; next state OUT_REQ.
REQ-022 OUT_REQ: when ack_s == 1, out_req <= 0; rd_ptr += 1 mod DEPTH; next state OUT_WAIT.
REQ-023 OUT_WAIT: when ack_s == 0, next state is OUT_IDLE.
REQ-024 Count SHALL increment on a write edge and decrement on a read edge (REQ-022); when both occur on the same edge, count SHALL be unchanged.
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0; count SHALL never exceed DEPTH or go below 0.
REQ-026 Data SHALL leave in arrival order; no entry is lost or duplicated.
REQ-027 Latency with empty buffer and no synchronisers: in_req high before edge E0 -> in_ack and count=1 after E0 -> out_req after E1.

Reset
REQ-028 While reset is high at a clock edge, the block SHALL set:
- in_ack=0, out_req=0, out_data=0
- wr_ptr=0, rd_ptr=0, count=0, full=0, empty=1
- FSMs to IN_IDLE and OUT_IDLE
- synchroniser flops to 0
REQ-029 Reset mid-transfer SHALL discard all buffered entries and any handshake in progress; buffer contents are not cleared.
REQ-030 After reset deasserts, the first transfer SHALL start only when req_s is sampled high.

Configuration
REQ-031 Macro HS_LINK_SYNC_EN:
- When defined: in_req and out_ack each pass through a two-flop synchroniser before use, adding 2 cycles to each sampled edge, so REQ-027 latency becomes 4 cycles.
- When undefined: raw inputs are used directly, and latency is as in REQ-027.

Verification
REQ-032 Reset, then one transfer with in_data=16'hA5A5 and out_ack echoing out_req after 1 cycle -> out_data=16'hA5A5 and count returns to 0; without the macro, out_req rises 2 cycles after in_req.
REQ-033 Hold out_ack=0 and push 5 words 1..5 with DEPTH=4 -> after 4 words, full=1 and count=4; the fifth in_ack stays 0 until the first read, then asserts; output order is 1,2,3,4,5.
REQ-034 Run continuous producer and consumer for 20 words -> count stays within 0..DEPTH, pointers wrap at least 4 times, and the output sequence matches the input.
REQ-035 Assert reset while out_req=1 and count=3 -> next cycle out_req=0, in_ack=0, count=0, empty=1; the next transfer after reset delivers new data only.
REQ-036 Arrange a write and a read acknowledge on the same edge with count=2 -> count=2 after that edge.
REQ-037 With HS_LINK_SYNC_EN defined, the single transfer of REQ-032 -> in_ack rises 3 cycles and out_req 4 cycles after in_req.

Source files
------------

// File: rtl/hs_link_buffer.sv
// Four-phase handshake link: producer and consumer handshakes joined by a DEPTH-entry circular buffer.
// Optional macro HS_LINK_SYNC_EN adds two-flop synchronisers on in_req and out_ack.
module hs_link_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_req,
  output logic                     in_ack,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_req,
  input  logic                     out_ack,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic       {IN_IDLE, IN_ACK}              in_state_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_WAIT}  out_state_e;

  in_state_e           in_state_q,  in_state_d;
  out_state_e          out_state_q, out_state_d;
  logic                in_ack_q,    in_ack_d;
  logic                out_req_q,   out_req_d;
  logic [DATA_W-1:0]   out_data_q,  out_data_d;
  logic [PW-1:0]       wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]       count_q,     count_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                req_s, ack_s;
  logic                wr_en, rd_en;

`ifdef HS_LINK_SYNC_EN
  logic [1:0] req_sync_q, ack_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_sync_q <= '0;
      ack_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[0], in_req};
      ack_sync_q <= {ack_sync_q[0], out_ack};
    end
  end

  assign req_s = req_sync_q[1];
  assign ack_s = ack_sync_q[1];
`else
  assign req_s = in_req;
  assign ack_s = out_ack;
`endif

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    in_state_d = in_state_q;
    in_ack_d   = in_ack_q;
    wr_en      = 1'b0;
    case (in_state_q)
      IN_IDLE: if (req_s && !full) begin
        wr_en      = 1'b1;
        in_ack_d   = 1'b1;
        in_state_d = IN_ACK;
      end
      IN_ACK: if (!req_s) begin
        in_ack_d   = 1'b0;
        in_state_d = IN_IDLE;
      end
      default: in_state_d = IN_IDLE;
    endcase
  end

  always_comb begin
    out_state_d = out_state_q;
    out_req_d   = out_req_q;
    out_data_d  = out_data_q;
    rd_en       = 1'b0;
    case (out_state_q)
      OUT_IDLE: if (!empty && !ack_s) begin
        out_data_d  = mem_q[rd_ptr_q];
        out_req_d   = 1'b1;
        out_state_d = OUT_REQ;
      end
      OUT_REQ: if (ack_s) begin
        out_req_d   = 1'b0;
        rd_en       = 1'b1;
        out_state_d = OUT_WAIT;
      end
      OUT_WAIT: if (!ack_s) out_state_d = OUT_IDLE;
      default:  out_state_d = OUT_IDLE;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (wr_en ? PW'(1) : PW'(0));
    rd_ptr_d = rd_ptr_q + (rd_en ? PW'(1) : PW'(0));
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_state_q  <= IN_IDLE;
      out_state_q <= OUT_IDLE;
      in_ack_q    <= 1'b0;
      out_req_q   <= 1'b0;
      out_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      in_ack_q    <= in_ack_d;
      out_req_q   <= out_req_d;
      out_data_q  <= out_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // NOTE: storage is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ack   = in_ack_q;
  assign out_req  = out_req_q;
  assign out_data = out_data_q;
  assign count    = count_q;

endmodule

// File: tb/tb_hs_link_buffer.sv
// Directed self-checking bench for hs_link_buffer; expected latencies follow HS_LINK_SYNC_EN.
module tb_hs_link_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int BUDGET = 100;

`ifdef HS_LINK_SYNC_EN
  localparam int LAT_ACK = 3;
  localparam int LAT_REQ = 4;
`else
  localparam int LAT_ACK = 1;
  localparam int LAT_REQ = 2;
`endif

  logic              clk;
  logic              reset;
  logic              in_req;
  logic              in_ack;
  logic [DATA_W-1:0] in_data;
  logic              out_req;
  logic              out_ack;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        count;
  logic              full;
  logic              empty;

  int tests_run = 0;
  int tests_failed = 0;

  hs_link_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_req   (in_req),
    .in_ack   (in_ack),
    .in_data  (in_data),
    .out_req  (out_req),
    .out_ack  (out_ack),
    .out_data (out_data),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ack(input logic v, input string tag);
    int n = 0;
    while (in_ack !== v && n < BUDGET) begin
      tick();
      n++;
    end
    if (in_ack !== v) check(tag, {31'b0, in_ack}, {31'b0, v});
  endtask

  task automatic wait_out_req(input logic v, input string tag);
    int n = 0;
    while (out_req !== v && n < BUDGET) begin
      tick();
      n++;
    end
    if (out_req !== v) check(tag, {31'b0, out_req}, {31'b0, v});
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    in_data = d;
    in_req  = 1'b1;
    wait_in_ack(1'b1, "push_ack_timeout");
    in_req  = 1'b0;
    wait_in_ack(1'b0, "push_release_timeout");
  endtask

  task automatic pop(output logic [DATA_W-1:0] d);
    wait_out_req(1'b1, "pop_req_timeout");
    d = out_data;
    tick();
    out_ack = 1'b1;
    wait_out_req(1'b0, "pop_release_timeout");
    out_ack = 1'b0;
  endtask

  logic [DATA_W-1:0] got;
  int   ack_at, req_at;
  logic [2:0] cnt_at_ack;
  logic [2:0] max_cnt;
  logic stream_done;

  initial begin
    reset = 1'b1; in_req = 1'b0; out_ack = 1'b0; in_data = '0;
    tick(); tick();
    check("rst_in_ack",   {31'b0, in_ack},  0);
    check("rst_out_req",  {31'b0, out_req}, 0);
    check("rst_out_data", {16'b0, out_data}, 0);
    check("rst_count",    {29'b0, count},   0);
    check("rst_full",     {31'b0, full},    0);
    check("rst_empty",    {31'b0, empty},   1);
    reset = 1'b0;
    tick(); tick();
    check("idle_no_ack",  {31'b0, in_ack},  0);

    // Single transfer and latency.
    in_data = 16'hA5A5; in_req = 1'b1;
    ack_at = 0; req_at = 0; cnt_at_ack = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (in_ack === 1'b1 && ack_at == 0) begin ack_at = i; cnt_at_ack = count; end
      if (out_req === 1'b1 && req_at == 0) req_at = i;
    end
    check("lat_in_ack",    ack_at, LAT_ACK);
    check("lat_out_req",   req_at, LAT_REQ);
    check("count_at_ack",  {29'b0, cnt_at_ack}, 1);
    in_req = 1'b0;
    pop(got);
    check("single_data",   {16'b0, got}, 32'hA5A5);
    repeat (6) tick();
    check("single_count",  {29'b0, count}, 0);
    check("single_empty",  {31'b0, empty}, 1);
    check("single_in_ack", {31'b0, in_ack}, 0);

    // Fill to full with consumer stalled; fifth word must wait for first read.
    for (int i = 1; i <= 4; i++) push(16'(i));
    repeat (2) tick();
    check("full_flag",  {31'b0, full},  1);
    check("full_count", {29'b0, count}, 4);
    in_data = 16'd5; in_req = 1'b1;
    repeat (6) tick();
    check("full_stall_ack",   {31'b0, in_ack}, 0);
    check("full_stall_count", {29'b0, count},  4);
    pop(got);
    check("order_1", {16'b0, got}, 1);
    wait_in_ack(1'b1, "fifth_ack_timeout");
    check("fifth_ack", {31'b0, in_ack}, 1);
    in_req = 1'b0;
    wait_in_ack(1'b0, "fifth_release_timeout");
    for (int i = 2; i <= 5; i++) begin
      pop(got);
      check("order_n", {16'b0, got}, i);
    end
    repeat (6) tick();
    check("drain_empty", {31'b0, empty}, 1);

    // Continuous stream of 20 words with jittered consumer.
    max_cnt = '0; stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          push(16'(100 + i));
          repeat ($urandom_range(0, 1)) tick();
        end
      end
      begin
        logic [DATA_W-1:0] d;
        for (int j = 0; j < 20; j++) begin
          repeat ($urandom_range(0, 2)) tick();
          pop(d);
          check("stream_data", {16'b0, d}, 100 + j);
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(negedge clk);
          if (count > max_cnt) max_cnt = count;
        end
      end
    join
    check("stream_max_le_depth", {31'b0, (max_cnt <= 3'(DEPTH))}, 1);
    repeat (6) tick();
    check("stream_empty", {31'b0, empty}, 1);

    // Simultaneous write and read acknowledge with count=2.
    push(16'hB001);
    push(16'hB002);
    wait_out_req(1'b1, "simul_req_timeout");
    repeat (2) tick();
    check("simul_pre_count", {29'b0, count}, 2);
    in_data = 16'hB003; in_req = 1'b1; out_ack = 1'b1;
    wait_in_ack(1'b1, "simul_ack_timeout");
    check("simul_count",   {29'b0, count},   2);
    check("simul_out_req", {31'b0, out_req}, 0);
    in_req = 1'b0; out_ack = 1'b0;
    wait_in_ack(1'b0, "simul_release_timeout");
    pop(got);
    check("simul_next_b002", {16'b0, got}, 32'hB002);
    pop(got);
    check("simul_next_b003", {16'b0, got}, 32'hB003);
    repeat (6) tick();

    // Reset mid-transfer discards buffered words.
    push(16'h0010); push(16'h0011); push(16'h0012);
    wait_out_req(1'b1, "mid_req_timeout");
    tick();
    check("mid_count",   {29'b0, count},   3);
    check("mid_out_req", {31'b0, out_req}, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_out_req", {31'b0, out_req}, 0);
    check("mid_rst_in_ack",  {31'b0, in_ack},  0);
    check("mid_rst_count",   {29'b0, count},   0);
    check("mid_rst_empty",   {31'b0, empty},   1);
    reset = 1'b0;
    repeat (4) tick();
    check("post_rst_idle",   {31'b0, out_req}, 0);
    push(16'h0077);
    pop(got);
    check("post_rst_data", {16'b0, got}, 32'h0077);
    repeat (6) tick();
    check("post_rst_empty", {31'b0, empty}, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
